// File: rtl/pc_seq_pkg.sv
// Shared definitions for the NPC PC sequencer: FSM state encoding,
// sequential PC step and the next-PC operand select encodings.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        HALT       = 3'd3,
        ERROR      = 3'd4
    } pc_state_e;

    localparam int unsigned PC_STEP = 4;

    // pc_a_sel picks the addend, pc_b_sel picks the base
    localparam logic PC_A_4   = 1'b0;
    localparam logic PC_A_IMM = 1'b1;
    localparam logic PC_B_PC  = 1'b0;
    localparam logic PC_B_RS1 = 1'b1;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC former: (a ? imm : 4) + (b ? rs1 : pc), bit0 cleared
// for register-based targets, plus misalign and taken (non-sequential) flags.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            pc_a_sel,
    input  logic            pc_b_sel,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign,
    output logic            taken
);

    logic [XLEN-1:0] offs;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] seq_pc;

    assign offs   = (pc_a_sel == PC_A_IMM) ? imm : XLEN'(PC_STEP);
    assign base   = (pc_b_sel == PC_B_RS1) ? rs1 : pc;
    assign sum    = base + offs;
    assign seq_pc = pc + XLEN'(PC_STEP);

    // register-relative targets drop bit0 before the alignment check
    assign next_pc  = (pc_b_sel == PC_B_RS1) ? {sum[XLEN-1:1], 1'b0} : sum;
    assign misalign = |next_pc[1:0];
    assign taken    = (next_pc != seq_pc);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle PC sequencer: fetch request/response, execute hand-off, next-PC
// update, halt and fetch-timeout/misalign error. PC_SEQ_STAT_EN adds commit counters.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = XLEN'(32'h8000_0000),
    parameter int              FETCH_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_rsp_valid,
    input  logic [31:0]     if_rsp_inst,
    output logic            ex_inst_valid,
    output logic [31:0]     ex_inst,
    output logic [XLEN-1:0] ex_pc,
    input  logic            ex_done,
    input  logic            pc_a_sel,
    input  logic            pc_b_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            halt,
`ifdef PC_SEQ_STAT_EN
    output logic [63:0]     instret,
    output logic [63:0]     taken_cnt,
`endif
    output logic            halted,
    output logic            err
);

    localparam int CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(FETCH_TIMEOUT);

    logic [2:0]      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0] calc_pc;
    logic            misalign;
    logic            taken;
    logic            rsp_take;
    logic            commit;

    pc_next_calc #(.XLEN(XLEN)) u_next (
        .pc       (pc),
        .imm      (imm),
        .rs1      (rs1),
        .pc_a_sel (pc_a_sel),
        .pc_b_sel (pc_b_sel),
        .next_pc  (calc_pc),
        .misalign (misalign),
        .taken    (taken)
    );

    assign if_req_addr = pc;
    assign rsp_take    = (state == FETCH_WAIT) && if_rsp_valid;
    assign commit      = (state == EXEC) && ex_done && !misalign;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            FETCH_REQ: begin
                if (if_req_valid && if_req_ready) begin
                    state_nxt = FETCH_WAIT;
                    cnt_nxt   = '0;
                end
            end
            FETCH_WAIT: begin
                cnt_nxt = cnt + 1'b1;
                // a response in the limit cycle still wins over the timeout
                if (if_rsp_valid)
                    state_nxt = EXEC;
                else if ((FETCH_TIMEOUT > 0) && (cnt_nxt == TO_LIM))
                    state_nxt = ERROR;
            end
            EXEC: begin
                if (ex_done) begin
                    pc_nxt = calc_pc;
                    if (misalign)
                        state_nxt = ERROR;
                    else if (halt)
                        state_nxt = HALT;
                    else
                        state_nxt = FETCH_REQ;
                end
            end
            default: ;
        endcase
    end

    // status outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH_REQ;
            pc            <= RESET_PC;
            cnt           <= '0;
            if_req_valid  <= 1'b0;
            ex_inst_valid <= 1'b0;
            ex_inst       <= '0;
            ex_pc         <= '0;
            halted        <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            cnt           <= cnt_nxt;
            if_req_valid  <= (state_nxt == FETCH_REQ);
            ex_inst_valid <= (state_nxt == EXEC);
            halted        <= (state_nxt == HALT);
            err           <= (state_nxt == ERROR);
            if (rsp_take) begin
                ex_inst <= if_rsp_inst;
                ex_pc   <= pc;
            end
        end
    end

`ifdef PC_SEQ_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret   <= '0;
            taken_cnt <= '0;
        end else if (commit) begin
            instret <= instret + 64'd1;
            if (taken)
                taken_cnt <= taken_cnt + 64'd1;
        end
    end
`else
    logic stat_unused;
    assign stat_unused = commit ^ taken;
`endif

endmodule
